// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared command encoding and pointer wrap helper for the SPI burst RAM
package spi_ram_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        SET_WADDR = 2'b00,
        WRITE     = 2'b01,
        SET_RADDR = 2'b10,
        READ      = 2'b11
    } cmd_t;

    // Wraps DEPTH-1 back to 0 so non-power-of-2 depths never leave the array.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// rtl/spi_ram_mem.sv - DEPTH x DATA_W single-port array, sync write and registered sync read
module spi_ram_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read register holds its word until the next accepted read; only it is reset.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// rtl/spi_ram_burst.sv - command decoder, burst pointers, tx handshake and sticky error flags
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int AUTO_INC = 1,
    localparam int PAY_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [CMD_W+PAY_W-1:0] din,
    input  logic                   tx_ready,
    input  logic                   clr_err,
    output logic                   tx_valid,
    output logic [DATA_W-1:0]      dout,
    output logic                   overrun,
    output logic                   addr_err
);

    cmd_t              cmd;
    logic [PAY_W-1:0]  payload;
    logic [ADDR_W-1:0] pay_addr;
    logic [DATA_W-1:0] pay_data;
    logic              bad_addr;

    logic [ADDR_W-1:0] waddr_d, waddr_q;
    logic [ADDR_W-1:0] raddr_d, raddr_q;
    logic              tx_valid_d, tx_valid_q;
    logic              overrun_d, overrun_q;
    logic              addr_err_d, addr_err_q;
    logic              mem_we, mem_re;

    assign cmd      = cmd_t'(din[CMD_W+PAY_W-1:PAY_W]);
    assign payload  = din[PAY_W-1:0];
    assign pay_addr = payload[ADDR_W-1:0];
    assign pay_data = payload[DATA_W-1:0];
    assign bad_addr = 32'(payload) >= 32'(DEPTH);

    always_comb begin
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        tx_valid_d = tx_valid_q;
        // A clear is applied first so an error raised on the same edge still sets the flag.
        overrun_d  = overrun_q & ~clr_err;
        addr_err_d = addr_err_q & ~clr_err;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        if (rx_valid) begin
            unique case (cmd)
                SET_WADDR: begin
                    if (bad_addr) addr_err_d = 1'b1;
                    else          waddr_d    = pay_addr;
                end
                WRITE: begin
                    mem_we = 1'b1;
                    if (AUTO_INC != 0) waddr_d = ADDR_W'(next_ptr(32'(waddr_q), DEPTH));
                end
                SET_RADDR: begin
                    if (bad_addr) addr_err_d = 1'b1;
                    else          raddr_d    = pay_addr;
                end
                READ: begin
                    // The holding slot is only free if empty or draining on this edge.
                    if (tx_valid_q && !tx_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        mem_re     = 1'b1;
                        tx_valid_d = 1'b1;
                        if (AUTO_INC != 0) raddr_d = ADDR_W'(next_ptr(32'(raddr_q), DEPTH));
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q    <= '0;
            raddr_q    <= '0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
            addr_err_q <= addr_err_d;
        end
    end

    spi_ram_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (waddr_q),
        .wdata (pay_data),
        .re    (mem_re),
        .raddr (raddr_q),
        .rdata (dout)
    );

    assign tx_valid = tx_valid_q;
    assign overrun  = overrun_q;
    assign addr_err = addr_err_q;

endmodule
